// File: rtl/pi_duty_controller_if.sv
// pi_duty_controller_if: regulator control/measurement inputs and duty/status outputs
interface pi_duty_controller_if;
  logic               i_enable;
  logic               i_sample_strobe;
  logic signed [15:0] i_setpoint;
  logic signed [15:0] i_measurement;
  logic        [15:0] i_kp;
  logic        [15:0] i_ki;
  logic        [31:0] o_pwm_duty;
  logic               o_duty_valid;
  logic               o_busy;
  logic               o_sat_hi;
  logic               o_sat_lo;
  logic               o_overrun;
  modport master (
    output i_enable, i_sample_strobe, i_setpoint, i_measurement, i_kp, i_ki,
    input  o_pwm_duty, o_duty_valid, o_busy, o_sat_hi, o_sat_lo, o_overrun
  );
  modport slave (
    input  i_enable, i_sample_strobe, i_setpoint, i_measurement, i_kp, i_ki,
    output o_pwm_duty, o_duty_valid, o_busy, o_sat_hi, o_sat_lo, o_overrun
  );
endinterface

// File: rtl/pi_duty_controller.sv
// pi_duty_controller: multi-cycle PI regulator for the half-bridge duty word; define PI_DUTY_SLEW_LIMIT_EN for per-update slew limiting
module pi_duty_controller #(
  parameter int DUTY_MID  = 2048,
  parameter int DUTY_MAX  = 4095,
  parameter int INT_LIM   = 2047,
  parameter int FRAC_BITS = 8
`ifdef PI_DUTY_SLEW_LIMIT_EN
  ,
  parameter int MAX_STEP  = 64
`endif
) (
  input logic i_clk,
  input logic i_rst,
  pi_duty_controller_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_ERROR, S_PROD, S_INTEG, S_SUM, S_CLAMP} state_t;
  localparam logic signed [35:0] L_MID   = 36'(DUTY_MID);
  localparam logic signed [35:0] L_MAX   = 36'(DUTY_MAX);
  localparam logic signed [33:0] L_ILIM  = 34'(INT_LIM);
  localparam logic signed [15:0] L_ILIM16 = 16'(INT_LIM);
  state_t             r_state;
  logic signed [15:0] r_sp, r_meas;
  logic        [15:0] r_kp, r_ki;
  logic signed [16:0] r_e;
  logic signed [32:0] r_p, r_di;
  logic signed [15:0] r_integ;
  logic signed [35:0] r_u;
  logic        [31:0] r_duty;
  logic               r_valid, r_busy, r_sat_hi, r_sat_lo, r_overrun;
  logic signed [16:0] w_e;
  logic signed [32:0] w_pp, w_pi, w_p, w_di;
  logic signed [33:0] w_isum;
  logic               w_hold;
  logic signed [15:0] w_integ;
  logic signed [35:0] w_u;
  logic               w_sat_hi, w_sat_lo;
  logic        [31:0] w_rng, w_next;
  always_comb begin
    w_e      = {r_sp[15], r_sp} - {r_meas[15], r_meas};
    w_pp     = r_e * $signed({1'b0, r_kp});
    w_pi     = r_e * $signed({1'b0, r_ki});
    w_p      = w_pp >>> FRAC_BITS;
    w_di     = w_pi >>> FRAC_BITS;
    // anti-windup uses the saturation flags left by the previous update
    w_hold   = (r_sat_hi && r_di > 0) || (r_sat_lo && r_di < 0);
    w_isum   = r_di + r_integ;
    w_integ  = w_hold ? r_integ : w_isum > L_ILIM ? L_ILIM16 : w_isum < -L_ILIM ? -L_ILIM16 : w_isum[15:0];
    w_u      = L_MID + r_p + r_integ;
    w_sat_hi = r_u > L_MAX;
    w_sat_lo = r_u < 0;
    w_rng    = w_sat_hi ? 32'(DUTY_MAX) : w_sat_lo ? 32'd0 : r_u[31:0];
`ifdef PI_DUTY_SLEW_LIMIT_EN
    w_next   = w_rng > r_duty + 32'(MAX_STEP) ? r_duty + 32'(MAX_STEP) :
               w_rng + 32'(MAX_STEP) < r_duty ? r_duty - 32'(MAX_STEP) : w_rng;
`else
    w_next   = w_rng;
`endif
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_sp      <= '0;
      r_meas    <= '0;
      r_kp      <= '0;
      r_ki      <= '0;
      r_e       <= '0;
      r_p       <= '0;
      r_di      <= '0;
      r_integ   <= '0;
      r_u       <= '0;
      r_duty    <= 32'(DUTY_MID);
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_sat_hi  <= 1'b0;
      r_sat_lo  <= 1'b0;
      r_overrun <= 1'b0;
    end else if (!bus.i_enable) begin
      r_state   <= S_IDLE;
      r_integ   <= '0;
      r_duty    <= 32'(DUTY_MID);
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_sat_hi  <= 1'b0;
      r_sat_lo  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bus.i_sample_strobe && r_state != S_IDLE) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (bus.i_sample_strobe) begin
          r_sp    <= bus.i_setpoint;
          r_meas  <= bus.i_measurement;
          r_kp    <= bus.i_kp;
          r_ki    <= bus.i_ki;
          r_busy  <= 1'b1;
          r_state <= S_ERROR;
        end
        S_ERROR: begin
          r_e     <= w_e;
          r_state <= S_PROD;
        end
        S_PROD: begin
          r_p     <= w_p;
          r_di    <= w_di;
          r_state <= S_INTEG;
        end
        S_INTEG: begin
          r_integ <= w_integ;
          r_state <= S_SUM;
        end
        S_SUM: begin
          r_u     <= w_u;
          r_state <= S_CLAMP;
        end
        S_CLAMP: begin
          r_duty   <= w_next;
          r_sat_hi <= w_sat_hi;
          r_sat_lo <= w_sat_lo;
          r_valid  <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
  assign bus.o_pwm_duty   = r_duty;
  assign bus.o_duty_valid = r_valid;
  assign bus.o_busy       = r_busy;
  assign bus.o_sat_hi     = r_sat_hi;
  assign bus.o_sat_lo     = r_sat_lo;
  assign bus.o_overrun    = r_overrun;
endmodule

// File: tb/tb_pi_duty_controller.sv
// tb_pi_duty_controller: directed checks of latency, PI math, clamping, anti-windup, overrun and enable/reset behaviour
module tb_pi_duty_controller;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   seen;
  pi_duty_controller_if bus ();
  pi_duty_controller dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic set_in(input int sp, input int meas, input int kp, input int ki);
    bus.i_setpoint    = 16'(sp);
    bus.i_measurement = 16'(meas);
    bus.i_kp          = 16'(kp);
    bus.i_ki          = 16'(ki);
  endtask
  task automatic pulse(input logic en);
    @(negedge clk);
    bus.i_enable        = en;
    bus.i_sample_strobe = 1'b1;
    @(negedge clk);
    bus.i_sample_strobe = 1'b0;
  endtask
  task automatic update(input string tag, input int exp_duty, input logic exp_hi, input logic exp_lo);
    int lat = 0;
    pulse(1'b1);
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.o_duty_valid) lat = k;
    end
    chk({tag, " latency"}, 64'(lat), 64'd5);
    chk({tag, " duty"}, 64'(bus.o_pwm_duty), 64'(exp_duty));
    chk({tag, " sat_hi"}, 64'(bus.o_sat_hi), 64'(exp_hi));
    chk({tag, " sat_lo"}, 64'(bus.o_sat_lo), 64'(exp_lo));
    @(negedge clk);
    chk({tag, " valid pulse"}, 64'(bus.o_duty_valid), 64'd0);
  endtask
  task automatic watch(input int n);
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.o_duty_valid) seen++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    bus.i_enable = 1'b0;
    bus.i_sample_strobe = 1'b0;
    set_in(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset duty", 64'(bus.o_pwm_duty), 64'd2048);
    chk("reset busy", 64'(bus.o_busy), 64'd0);
    chk("reset valid", 64'(bus.o_duty_valid), 64'd0);
    chk("reset flags", 64'({bus.o_sat_hi, bus.o_sat_lo, bus.o_overrun}), 64'd0);
    rst = 1'b0;
    bus.i_enable = 1'b1;
`ifdef PI_DUTY_SLEW_LIMIT_EN
    set_in(100, 0, 256, 0);
    update("slew1", 2112, 1'b0, 1'b0);
    update("slew2", 2148, 1'b0, 1'b0);
`else
    set_in(100, 0, 256, 0);
    update("p only", 2148, 1'b0, 1'b0);
    pulse(1'b1);
    repeat (2) @(negedge clk);
    chk("pre-reset busy", 64'(bus.o_busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid reset busy", 64'(bus.o_busy), 64'd0);
    chk("mid reset duty", 64'(bus.o_pwm_duty), 64'd2048);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 1) rst = 1'b0;
      if (bus.o_duty_valid) seen++;
    end
    chk("mid reset no valid", 64'(seen), 64'd0);
    chk("mid reset flags", 64'({bus.o_busy, bus.o_sat_hi, bus.o_sat_lo, bus.o_overrun}), 64'd0);
    set_in(10, 0, 0, 128);
    update("integ1", 2053, 1'b0, 1'b0);
    update("integ2", 2058, 1'b0, 1'b0);
    update("integ3", 2063, 1'b0, 1'b0);
    update("integ4", 2068, 1'b0, 1'b0);
    bus.i_enable = 1'b0;
    @(negedge clk);
    chk("disable duty", 64'(bus.o_pwm_duty), 64'd2048);
    chk("disable integ", 64'(dut.r_integ), 64'd0);
    bus.i_enable = 1'b1;
    set_in(5000, 0, 256, 256);
    update("wind1", 4095, 1'b1, 1'b0);
    chk("wind1 integ", 64'(dut.r_integ), 64'd2047);
    update("wind2", 4095, 1'b1, 1'b0);
    chk("wind2 integ", 64'(dut.r_integ), 64'd2047);
    set_in(0, 100, 0, 256);
    update("unwind", 3995, 1'b0, 1'b0);
    chk("unwind integ", 64'(dut.r_integ), 64'd1947);
    set_in(0, 5000, 256, 0);
    update("low clamp", 0, 1'b0, 1'b1);
    set_in(0, 1, 128, 0);
    update("floor shift", 3994, 1'b0, 1'b0);
    pulse(1'b1);
    @(negedge clk);
    bus.i_sample_strobe = 1'b1;
    @(negedge clk);
    bus.i_sample_strobe = 1'b0;
    watch(12);
    chk("overrun valid count", 64'(seen), 64'd1);
    chk("overrun flag", 64'(bus.o_overrun), 64'd1);
    chk("overrun duty", 64'(bus.o_pwm_duty), 64'd3994);
    bus.i_enable = 1'b0;
    @(negedge clk);
    chk("overrun clear duty", 64'(bus.o_pwm_duty), 64'd2048);
    chk("overrun clear flag", 64'(bus.o_overrun), 64'd0);
    pulse(1'b0);
    chk("disabled strobe busy", 64'(bus.o_busy), 64'd0);
    watch(7);
    chk("disabled strobe valid", 64'(seen), 64'd0);
    set_in(100, 0, 256, 0);
    pulse(1'b1);
    @(negedge clk);
    bus.i_enable = 1'b0;
    watch(8);
    chk("abort no valid", 64'(seen), 64'd0);
    chk("abort duty", 64'(bus.o_pwm_duty), 64'd2048);
    update("enable rise", 2148, 1'b0, 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pi_duty_controller.md
Name: pi_duty_controller

Overview:
- Closed-loop PI regulator that computes the 32-bit duty word consumed by the half-bridge PWM stage.
- Duty scale is 0..4095. 2048 is neutral. Below 2048 drives the high side; above 2048 drives the low side.
- Each sample_strobe starts a fixed-latency, multi-cycle computation. The result is held on PWM_DUTY until the next update.
- Sits between the sensor/ADC front end (measurement) and the PWM stage.

Parameters:
- DUTY_MID, 2048, neutral duty value; reset/disabled output.
- DUTY_MAX, 4095, upper clamp of PWM_DUTY (lower clamp is 0).
- INT_LIM, 2047, symmetric integrator clamp ±INT_LIM.
- FRAC_BITS, 8, fractional bits of kp/ki (unsigned Q8.8 at default).
- MAX_STEP, 64, max PWM_DUTY change per update (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  regulator run; low = neutral output, integrator cleared
- sample_strobe  in  1  one-cycle pulse; starts one PI update
- setpoint  in  16  signed target
- measurement  in  16  signed feedback
- kp  in  16  unsigned proportional gain, Q(16-FRAC_BITS).FRAC_BITS
- ki  in  16  unsigned integral gain, same format
- PWM_DUTY  out  32  duty word to the PWM stage, range 0..DUTY_MAX, zero-extended
- duty_valid  out  1  one-cycle pulse when PWM_DUTY updates
- busy  out  1  high while the FSM is not in IDLE
- sat_hi  out  1  last result clamped at DUTY_MAX
- sat_lo  out  1  last result clamped at 0
- overrun  out  1  sticky; a strobe arrived while busy

Behaviour:
- Reset values (asynchronous): PWM_DUTY=DUTY_MID, integrator=0, state=IDLE, duty_valid=0, busy=0, sat_hi=0, sat_lo=0, overrun=0.
- FSM states: IDLE -> ERROR -> PROD -> INTEG -> SUM -> CLAMP -> IDLE. One cycle per state, no stalls.
- IDLE:
  - On sample_strobe=1 with enable=1, latch setpoint, measurement, kp and ki, then go to ERROR.
  - Inputs that change later do not affect the update in progress.
- ERROR: e = setpoint - measurement, 17-bit signed, no overflow possible.
- PROD:
  - p = (e*kp) >>> FRAC_BITS
  - di = (e*ki) >>> FRAC_BITS
  - Products are 33-bit signed. The shift is arithmetic (floor toward -inf).
- INTEG (anti-windup):
  - If sat_hi=1 and di>0, or sat_lo=1 and di<0, the integrator holds.
  - Otherwise integ = clamp(integ+di, -INT_LIM, +INT_LIM).
  - sat_hi/sat_lo here are the flags from the previous update.
- SUM: u = DUTY_MID + p + integ, using the updated integrator, in 36-bit signed.
- CLAMP:
  - u>DUTY_MAX gives DUTY_MAX with sat_hi=1.
  - u<0 gives 0 with sat_lo=1.
  - Otherwise u, with both flags 0.
  - PWM_DUTY registers the result and duty_valid pulses in the same cycle.
- Latency: duty_valid is high exactly 5 cycles after the clock edge that sampled the strobe. Minimum strobe spacing is 6 cycles.
- busy is high in ERROR through CLAMP inclusive.
- A strobe sampled while busy is ignored and sets overrun=1. The current computation is unaffected.
- enable=0 at any cycle (overrides the FSM, including mid-operation):
  - Next edge: state=IDLE, PWM_DUTY=DUTY_MID, integrator=0, sat flags=0, overrun=0.
  - No duty_valid pulse.
  - Strobes are ignored while enable=0.
- Reset mid-operation aborts the update with no duty_valid pulse.
- Strobe in the same cycle as enable rising is accepted.

Optional Feature:
- Macro: PI_DUTY_SLEW_LIMIT_EN.
- Defined: CLAMP output is further limited to PWM_DUTY_prev ± MAX_STEP. Sat flags reflect the range clamp only. Latency is unchanged.
- Not defined: no slew limiting; MAX_STEP is unused.

Test Plan:
- Reset asserted mid-computation -> PWM_DUTY=2048, duty_valid never pulses, busy=0, all flags 0.
- setpoint=100, measurement=0, kp=0x0100, ki=0 -> PWM_DUTY=2148 with duty_valid exactly 5 cycles after the strobe.
- kp=0, ki=0x0080, error=10, four strobes -> PWM_DUTY = 2053, 2058, 2063, 2068.
- Windup case:
  - setpoint=5000, kp=0x0100, ki=0x0100 -> 4095 with sat_hi=1 and integ=2047.
  - A second strobe leaves integ at 2047.
  - Then setpoint=0, measurement=100, kp=0 -> 3995 with sat_hi=0.
- Strobe 2 cycles after a previous strobe -> ignored, overrun=1, one duty_valid. Then enable=0 -> PWM_DUTY=2048 and overrun=0.
- With PI_DUTY_SLEW_LIMIT_EN, MAX_STEP=64, target 2148 from 2048 -> 2112, then 2148 on the next strobe.
